// File: rtl/scan_reg_bank.sv
// Register bank with scan shift and Galois MISR signature modes.
// SDONE pulses once for each uninterrupted run of WIDTH shifts.
module scan_reg_bank #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 'h1D
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             SE,
  input  logic             SI,
  input  logic             ME,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             SDONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] shift_next, misr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sdone_reg, sdone_next;

  // Per-bit shift and MISR candidates; bit 0 takes SI or the compaction input.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shift_next[gi] = SI;
        assign misr_next[gi]  = (q_reg[WIDTH-1] & POLY[gi]) ^ D[gi];
      end else begin : g_upper
        assign shift_next[gi] = q_reg[gi-1];
        assign misr_next[gi]  = q_reg[gi-1] ^ (q_reg[WIDTH-1] & POLY[gi]) ^ D[gi];
      end
    end
  endgenerate

  always_comb begin
    q_next     = q_reg;
    cnt_next   = '0;
    sdone_next = 1'b0;
    if (SE) begin
      q_next = shift_next;
      if (cnt_reg == CNT_LAST) begin
        sdone_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else if (ME) begin
      q_next = misr_next;
    end else if (EN) begin
      q_next = D;
    end
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      q_reg     <= '0;
      cnt_reg   <= '0;
      sdone_reg <= 1'b0;
    end else begin
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      sdone_reg <= sdone_next;
    end
  end

  assign Q     = q_reg;
  assign SO    = q_reg[WIDTH-1];
  assign SDONE = sdone_reg;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed self-checking bench for scan_reg_bank at WIDTH=8, POLY=8'h1D.
module tb_scan_reg_bank;

  logic       CP = 1'b0;
  logic       CDN = 1'b0;
  logic [7:0] D = 8'h00;
  logic       EN = 1'b0, SE = 1'b0, SI = 1'b0, ME = 1'b0;
  logic [7:0] Q;
  logic       SO, SDONE;

  int tests = 0;
  int fails = 0;

  scan_reg_bank #(.WIDTH(8), .POLY(8'h1D)) dut (
    .CP(CP), .CDN(CDN), .D(D), .EN(EN), .SE(SE), .SI(SI), .ME(ME),
    .Q(Q), .SO(SO), .SDONE(SDONE)
  );

  always #5 CP = ~CP;

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] so_exp;
    so_exp = 8'b1010_0101;

    // Reset state
    #3;
    chk("reset_q", Q, 8'h00);
    chk("reset_so", {7'b0, SO}, 8'h00);
    chk("reset_sdone", {7'b0, SDONE}, 8'h00);
    @(posedge CP); #2; CDN = 1'b1;

    // Functional load and hold
    EN = 1'b1; D = 8'hA5; tick();
    chk("load_a5", Q, 8'hA5);
    EN = 1'b0; D = 8'hFF; tick();
    chk("hold_a5", Q, 8'hA5);

    // Full shift out of A5, MSB first
    SE = 1'b1; SI = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("shift_so_%0d", i), {7'b0, SO}, {7'b0, so_exp[7-i]});
      chk($sformatf("shift_sdone_%0d", i), {7'b0, SDONE}, 8'h00);
      tick();
    end
    chk("shift_q", Q, 8'h00);
    chk("shift_sdone_done", {7'b0, SDONE}, 8'h01);
    SE = 1'b0; tick();
    chk("sdone_drop", {7'b0, SDONE}, 8'h00);

    // Interrupted shift sequence
    SE = 1'b1; SI = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("intr_sdone_%0d", i), {7'b0, SDONE}, 8'h00);
    end
    SE = 1'b0; tick();
    chk("intr_gap_sdone", {7'b0, SDONE}, 8'h00);
    SE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("b2b_sdone_%0d", i), {7'b0, SDONE}, (i == 7 || i == 15) ? 8'h01 : 8'h00);
    end
    chk("b2b_q", Q, 8'hFF);

    // Reset while SDONE is high clears everything at once
    CDN = 1'b0; #1;
    chk("rst_sdone_q", Q, 8'h00);
    chk("rst_sdone_sdone", {7'b0, SDONE}, 8'h00);
    CDN = 1'b1; SE = 1'b0;

    // MISR accumulation
    ME = 1'b1; D = 8'h01; tick();
    chk("misr_first", Q, 8'h01);
    D = 8'h00;
    for (int i = 0; i < 7; i++) tick();
    chk("misr_80", Q, 8'h80);
    tick();
    chk("misr_fb_1d", Q, 8'h1D);
    D = 8'hFF; tick();
    chk("misr_xor_d", Q, 8'hC5);

    // Priority: shift wins over MISR and load
    SE = 1'b1; ME = 1'b1; EN = 1'b1; D = 8'h55; SI = 1'b1; tick();
    chk("prio_shift_si1", Q, 8'h8B);
    SI = 1'b0; tick();
    chk("prio_shift_si0", Q, 8'h16);
    // MISR wins over load
    SE = 1'b0; D = 8'h00; tick();
    chk("prio_misr", Q, 8'h2C);
    ME = 1'b0; EN = 1'b0; D = 8'hAA; tick();
    chk("hold_2c", Q, 8'h2C);

    // Reset mid-shift abandons the count
    EN = 1'b1; D = 8'h5A; tick();
    EN = 1'b0; SE = 1'b1; SI = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_q", Q, 8'hD0);
    CDN = 1'b0; #1;
    chk("midrst_q", Q, 8'h00);
    chk("midrst_so", {7'b0, SO}, 8'h00);
    chk("midrst_sdone", {7'b0, SDONE}, 8'h00);
    CDN = 1'b1; SI = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post_rst_sdone_%0d", i), {7'b0, SDONE}, (i == 7) ? 8'h01 : 8'h00);
    end
    chk("post_rst_q", Q, 8'hFF);
    SE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_reg_bank.md
SCAN_REG_BANK -- requirements
Module: scan_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register and scan-chain length in bits (legal range 2..64).
REQ-002 SHALL have parameter POLY, default 8'h1D (WIDTH bits), meaning the Galois feedback polynomial for MISR mode.
REQ-003 SHALL have port CP, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port CDN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port D, input, WIDTH bits: functional data, also the MISR compaction input.
REQ-006 SHALL have port EN, input, 1 bit: functional load enable.
REQ-007 SHALL have port SE, input, 1 bit: scan shift enable.
REQ-008 SHALL have port SI, input, 1 bit: scan serial input.
REQ-009 SHALL have port ME, input, 1 bit: MISR (signature) mode enable.
REQ-010 SHALL have port Q, output, WIDTH bits: register contents.
REQ-011 SHALL have port SO, output, 1 bit: scan serial output, equal to Q[WIDTH-1] (combinational from Q).
REQ-012 SHALL have port SDONE, output, 1 bit: registered one-cycle pulse marking a completed full-length shift.

Function
REQ-013 SHALL apply mode priority each CP edge as SE > ME > EN > hold.
REQ-014 SHALL, with SE=1, update Q <= {Q[WIDTH-2:0], SI}, shifting MSB first out on SO.
REQ-015 SHALL, with SE=0 and ME=1, update Q <= ({Q[WIDTH-2:0],1'b0} ^ (Q[WIDTH-1] ? POLY : 0)) ^ D.
REQ-016 SHALL, with SE=0, ME=0 and EN=1, update Q <= D.
REQ-017 SHALL, with SE=0, ME=0 and EN=0, hold Q unchanged.
REQ-018 SHALL keep an internal shift counter of ceil(log2(WIDTH)) bits, incremented on every edge with SE=1.
REQ-019 SHALL wrap the counter to 0 on the edge that completes the WIDTH-th consecutive shift, and assert SDONE for exactly the following cycle.
REQ-020 SHALL clear the counter to 0 on any edge with SE=0, so an interrupted shift sequence never produces SDONE.
REQ-021 SHALL, for back-to-back full shifts with SE held high, pulse SDONE once every WIDTH cycles.
REQ-022 SHALL drive SDONE low on every edge not covered by REQ-019.
REQ-023 SHALL have latency of one CP edge from any mode input to Q, and zero from Q to SO.

Reset
REQ-024 SHALL, while CDN=0, force Q=0, counter=0 and SDONE=0 immediately, independent of CP.
REQ-025 SHALL abandon any in-progress shift or MISR accumulation on reset; the first edge after CDN rises is treated as the first cycle of a new sequence.
REQ-026 SHALL leave SO=0 during reset as a consequence of Q=0.

Verification (WIDTH=8, POLY=8'h1D)
REQ-027 SHALL cover: Q=8'h5A with 3 shifts done, then CDN pulsed low between edges -> Q=8'h00, SO=0 and SDONE=0 at once; then 8 shifts -> SDONE after the 8th shift.
REQ-028 SHALL cover: EN=1, D=8'hA5 -> Q=8'hA5; then EN=0, D=8'hFF -> Q stays 8'hA5.
REQ-029 SHALL cover: Q=8'hA5, SE=1, SI=0 for 8 edges -> SO sequence 1,0,1,0,0,1,0,1; Q=8'h00; SDONE high only in the cycle after the 8th edge.
REQ-030 SHALL cover: 5 shifts, then SE=0 for one edge, then 8 shifts -> no SDONE after the first 5; SDONE only after the 8th later shift.
REQ-031 SHALL cover: Q=8'h00, ME=1, D=8'h01 -> Q=8'h01; D=8'h00 for 7 edges -> Q=8'h80; one more edge -> Q=8'h1D.
REQ-032 SHALL cover: SE=1, ME=1 and EN=1 together -> shift behaviour only; D is ignored.
